// File: rtl/sp_prefetch.sv
// Sprite prefetcher: fetches job_len words from a toggle-handshake SDRAM port into a small FIFO.
// Latency: first sp_req toggle the cycle after job_start; out_valid one cycle after each ack match.
// Backpressure: out_ready=0 fills the FIFO and stalls further requests; nothing is dropped.
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   job_start/job_addr/job_len start a job (len 0 = 256 words); job_busy high while working
//   sp_addr/sp_req/sp_ack/sp_q toggle-handshake read port (one request outstanding)
//   out_data/out_valid/out_ready/out_last  valid-ready output stream, last tags final word
module sp_prefetch #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        job_start,
  input  logic [19:0] job_addr,
  input  logic [7:0]  job_len,
  output logic        job_busy,
  output logic [19:0] sp_addr,
  output logic        sp_req,
  input  logic        sp_ack,
  input  logic [31:0] sp_q,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DRAIN,
    S_FLUSH
  } state_t;

  state_t      state;
  logic [19:0] addr_cnt;
  logic [8:0]  remaining;
  logic [19:0] sp_addr_q;
  // Never reset: clearing it would look like a new request to the toggle port.
  logic        sp_req_q = 1'b0;

  logic [31:0]           mem_dat [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_last;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         fifo_count;

  logic ack_match;
  logic push;
  logic pop;
  logic can_issue;

  assign ack_match = (sp_ack == sp_req_q);
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign push      = (state == S_WAIT) && ack_match;
  // Issue only while at least one slot stays free for the outstanding word,
  // so a push can never hit a full FIFO.
  assign can_issue = ((32'(fifo_count) + 1) <= (FIFO_DEPTH - 1)) || pop;

  assign out_data = out_valid ? mem_dat[rd_ptr] : 32'd0;
  assign out_last = out_valid && mem_last[rd_ptr];
  assign sp_addr  = sp_addr_q;
  assign sp_req   = sp_req_q;
  assign job_busy = (state != S_IDLE);

  // FIFO storage: no reset needed, the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_dat[wr_ptr]  <= sp_q;
      mem_last[wr_ptr] <= (remaining == 9'd1);
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      addr_cnt  <= '0;
      remaining <= '0;
      sp_addr_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!ack_match) begin
            // A request was in flight when reset hit; wait it out.
            state <= S_FLUSH;
          end else if (job_start) begin
            // The FIFO is always empty in IDLE, so the first fetch is issued
            // directly from here to get the toggle out one cycle after job_start.
            addr_cnt  <= job_addr;
            remaining <= (job_len == 8'd0) ? 9'd256 : {1'b0, job_len};
            sp_addr_q <= job_addr;
            sp_req_q  <= ~sp_req_q;
            state     <= S_WAIT;
          end
        end
        S_FETCH: begin
          if (can_issue) begin
            sp_addr_q <= addr_cnt;
            sp_req_q  <= ~sp_req_q;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (ack_match) begin
            addr_cnt  <= addr_cnt + 20'd1;
            remaining <= remaining - 9'd1;
            state     <= (remaining > 9'd1) ? S_FETCH : S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop && out_last) state <= S_IDLE;
        end
        S_FLUSH: begin
          // Returned data is discarded.
          if (ack_match) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sp_prefetch.sv
module tb_sp_prefetch;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        job_start = 1'b0;
  logic [19:0] job_addr = '0;
  logic [7:0]  job_len = '0;
  logic        job_busy;
  logic [19:0] sp_addr;
  logic        sp_req;
  logic        sp_ack = 1'b0;
  logic [31:0] sp_q = '0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;

  int errors = 0;
  int checks = 0;
  int ack_delay = 7;
  int ack_cnt = 0;

  logic [19:0] addr_q [$];
  logic [31:0] dat_q [$];
  logic        last_q [$];
  logic        prev_req = 1'b0;

  always #5 clk = ~clk;

  sp_prefetch #(.FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .job_start(job_start),
    .job_addr (job_addr),
    .job_len  (job_len),
    .job_busy (job_busy),
    .sp_addr  (sp_addr),
    .sp_req   (sp_req),
    .sp_ack   (sp_ack),
    .sp_q     (sp_q),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last)
  );

  // SDRAM responder and stream monitors, all on the falling edge.
  always @(negedge clk) begin
    if (sp_req !== prev_req) begin
      addr_q.push_back(sp_addr);
      prev_req = sp_req;
    end
    if (out_valid && out_ready) begin
      dat_q.push_back(out_data);
      last_q.push_back(out_last);
    end
    if (sp_ack != sp_req) begin
      if (ack_cnt >= ack_delay - 1) begin
        sp_ack  = sp_req;
        sp_q    = {12'hC0D, sp_addr};
        ack_cnt = 0;
      end else begin
        ack_cnt++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [19:0] a, input logic [7:0] l);
    @(posedge clk);
    #1;
    job_addr  = a;
    job_len   = l;
    job_start = 1'b1;
    @(posedge clk);
    #1;
    job_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n = 0;
    while (job_busy === 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, {31'd0, job_busy}, 32'd0);
  endtask

  task automatic verify_job(input string tag, input int abase, input int dbase,
                            input logic [19:0] a0, input int n);
    logic [19:0] a;
    check({tag, "_req_count"}, addr_q.size() - abase, n);
    check({tag, "_word_count"}, dat_q.size() - dbase, n);
    for (int i = 0; i < n; i++) begin
      a = a0 + 20'(i);
      if (abase + i < addr_q.size())
        check($sformatf("%s_addr%0d", tag, i), {12'd0, addr_q[abase + i]}, {12'd0, a});
      if (dbase + i < dat_q.size()) begin
        check($sformatf("%s_data%0d", tag, i), dat_q[dbase + i], {12'hC0D, a});
        check($sformatf("%s_last%0d", tag, i), {31'd0, last_q[dbase + i]},
              (i == n - 1) ? 32'd1 : 32'd0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int abase;
    int dbase;
    int tog_hold;
    logic rb;
    logic exp_req;
    logic saved_req;

    // Reset, with a job_start pulse that must be ignored.
    tick(2);
    job_addr  = 20'h00ABC;
    job_len   = 8'd2;
    job_start = 1'b1;
    tick(1);
    job_start = 1'b0;
    check("rst_sp_req", {31'd0, sp_req}, 32'd0);
    check("rst_busy", {31'd0, job_busy}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_last", {31'd0, out_last}, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_addr", {12'd0, sp_addr}, 32'd0);
    reset = 1'b0;
    tick(3);
    check("rst_start_ignored_busy", {31'd0, job_busy}, 32'd0);
    check("rst_start_ignored_req", addr_q.size(), 0);

    // Basic job.
    abase = addr_q.size();
    dbase = dat_q.size();
    rb = sp_req;
    exp_req = ~rb;
    start_job(20'h00100, 8'd3);
    check("t1_latency", {31'd0, sp_req}, {31'd0, exp_req});
    check("t1_first_addr", {12'd0, sp_addr}, 32'h00100);
    check("t1_busy", {31'd0, job_busy}, 32'd1);
    wait_idle("t1", 200);
    verify_job("t1", abase, dbase, 20'h00100, 3);

    // Backpressure.
    out_ready = 1'b0;
    abase = addr_q.size();
    dbase = dat_q.size();
    start_job(20'h00400, 8'd10);
    tick(150);
    check("t2_req_le_depth", {31'd0, (addr_q.size() - abase) <= DEPTH}, 32'd1);
    check("t2_no_output", dat_q.size() - dbase, 0);
    check("t2_valid", {31'd0, out_valid}, 32'd1);
    check("t2_busy", {31'd0, job_busy}, 32'd1);
    tog_hold = addr_q.size();
    tick(50);
    check("t2_stalled", addr_q.size(), tog_hold);
    out_ready = 1'b1;
    wait_idle("t2", 400);
    verify_job("t2", abase, dbase, 20'h00400, 10);

    // Address wrap.
    abase = addr_q.size();
    dbase = dat_q.size();
    start_job(20'hFFFFF, 8'd2);
    wait_idle("t3", 200);
    verify_job("t3", abase, dbase, 20'hFFFFF, 2);

    // job_len = 0 means 256 words.
    abase = addr_q.size();
    dbase = dat_q.size();
    start_job(20'h01000, 8'd0);
    wait_idle("t4", 4000);
    verify_job("t4", abase, dbase, 20'h01000, 256);

    // Second job_start during a job is ignored.
    abase = addr_q.size();
    dbase = dat_q.size();
    start_job(20'h00200, 8'd3);
    tick(2);
    job_addr  = 20'h00300;
    job_len   = 8'd5;
    job_start = 1'b1;
    tick(1);
    job_start = 1'b0;
    wait_idle("t5", 200);
    verify_job("t5", abase, dbase, 20'h00200, 3);

    // Reset while a request is outstanding.
    ack_delay = 10;
    abase = addr_q.size();
    dbase = dat_q.size();
    start_job(20'h00500, 8'd4);
    tick(3);
    saved_req = sp_req;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("t6_req_kept", {31'd0, sp_req}, {31'd0, saved_req});
    tick(1);
    check("t6_flush_busy", {31'd0, job_busy}, 32'd1);
    check("t6_flush_pending", {31'd0, sp_ack != sp_req}, 32'd1);
    wait_idle("t6", 50);
    check("t6_ack_done", {31'd0, sp_ack == sp_req}, 32'd1);
    check("t6_no_push", dat_q.size() - dbase, 0);
    check("t6_no_valid", {31'd0, out_valid}, 32'd0);
    check("t6_single_req", addr_q.size() - abase, 1);
    ack_delay = 7;
    abase = addr_q.size();
    dbase = dat_q.size();
    start_job(20'h00055, 8'd1);
    wait_idle("t6b", 200);
    verify_job("t6b", abase, dbase, 20'h00055, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
